// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan driver.
package seg7_pkg;

    localparam int SEG_A = 7;
    localparam int SEG_B = 6;
    localparam int SEG_C = 5;
    localparam int SEG_D = 4;
    localparam int SEG_E = 3;
    localparam int SEG_F = 2;
    localparam int SEG_G = 1;
    localparam int SEG_H = 0;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Segment order is {a,b,c,d,e,f,g,h}; the dot (h) is always 0 here.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0:    s = 8'hFC;
            4'h1:    s = 8'h60;
            4'h2:    s = 8'hDA;
            4'h3:    s = 8'hF2;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'hB6;
            4'h6:    s = 8'hBE;
            4'h7:    s = 8'hE0;
            4'h8:    s = 8'hFE;
            4'h9:    s = 8'hF6;
            4'hA:    s = 8'hEE;
            4'hB:    s = 8'h3E;
            4'hC:    s = 8'h9C;
            4'hD:    s = 8'h7A;
            4'hE:    s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble + dot to 8-bit segment pattern (a..g, h).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dot,
    output logic [7:0] seg
);

    always_comb begin
        seg        = hex_to_seg(nibble);
        seg[SEG_H] = dot;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered hex/dot/enable data,
// one blank cycle between digit slots, optional leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int clk_mhz    = 50,
    parameter int w_digit    = 8,
    parameter int refresh_hz = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [4*w_digit-1:0]   number,
    input  logic [w_digit-1:0]     dots,
    input  logic [w_digit-1:0]     en_mask,
    input  logic                   blank_lz,
    output logic [7:0]             abcdefgh,
    output logic [w_digit-1:0]     digit,
    output logic                   frame_start
);

    localparam int PERIOD = (clk_mhz * 1000000) / (refresh_hz * w_digit);
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IDX_W  = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(w_digit - 1);

    if (w_digit < 1) begin : g_wdigit_check
        $error("seg7_scan_driver: w_digit must be at least 1");
    end
    if (PERIOD < 2) begin : g_period_check
        $error("seg7_scan_driver: PERIOD must be at least 2");
    end

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           abcdefgh_q, abcdefgh_d;
    logic [w_digit-1:0]   digit_q, digit_d;
    logic                 frame_start_q, frame_start_d;
    logic [4*w_digit-1:0] pend_number_q, pend_number_d;
    logic [w_digit-1:0]   pend_dots_q, pend_dots_d;
    logic [w_digit-1:0]   pend_en_q, pend_en_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [4*w_digit-1:0] sh_number_q, sh_number_d;
    logic [w_digit-1:0]   sh_dots_q, sh_dots_d;
    logic [w_digit-1:0]   sh_en_q, sh_en_d;

    logic                 tick, wrap;
    logic [w_digit-1:0]   lz_blank;
    logic [w_digit-1:0]   onehot;
    logic                 upper_zero;
    logic [3:0]           cur_nib;
    logic                 cur_dot, cur_en, cur_lz;
    logic [7:0]           dec_seg;

    // Per-digit view of the shadow data for the digit currently being scanned.
    always_comb begin
        lz_blank   = '0;
        onehot     = '0;
        upper_zero = 1'b1;
        cur_nib    = 4'h0;
        cur_dot    = 1'b0;
        cur_en     = 1'b0;
        cur_lz     = 1'b0;
        for (int i = w_digit - 1; i >= 0; i--) begin
            upper_zero  = upper_zero && (sh_number_q[4*i +: 4] == 4'h0);
            lz_blank[i] = blank_lz && (i != 0) && upper_zero;
        end
        for (int i = 0; i < w_digit; i++) begin
            if (idx_q == IDX_W'(i)) begin
                onehot[i] = 1'b1;
                cur_nib   = sh_number_q[4*i +: 4];
                cur_dot   = sh_dots_q[i];
                cur_en    = sh_en_q[i];
                cur_lz    = lz_blank[i];
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble (cur_nib),
        .dot    (cur_dot),
        .seg    (dec_seg)
    );

    always_comb begin
        tick          = (cnt_q == CNT_LAST);
        wrap          = tick && (idx_q == IDX_LAST);
        cnt_d         = tick ? '0 : cnt_q + 1'b1;
        idx_d         = idx_q;
        pend_number_d = pend_number_q;
        pend_dots_d   = pend_dots_q;
        pend_en_d     = pend_en_q;
        pend_valid_d  = pend_valid_q;
        sh_number_d   = sh_number_q;
        sh_dots_d     = sh_dots_q;
        sh_en_d       = sh_en_q;
        frame_start_d = wrap;
        digit_d       = '0;
        abcdefgh_d    = SEG_BLANK;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Shadow only changes at the frame boundary; a load landing on it bypasses pending.
        if (wrap) begin
            if (load) begin
                sh_number_d  = number;
                sh_dots_d    = dots;
                sh_en_d      = en_mask;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                sh_number_d  = pend_number_q;
                sh_dots_d    = pend_dots_q;
                sh_en_d      = pend_en_q;
                pend_valid_d = 1'b0;
            end
        end else if (load) begin
            pend_number_d = number;
            pend_dots_d   = dots;
            pend_en_d     = en_mask;
            pend_valid_d  = 1'b1;
        end

        if (!tick) begin
            digit_d    = onehot;
            abcdefgh_d = (cur_en && !cur_lz) ? dec_seg : SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            abcdefgh_q    <= '0;
            digit_q       <= '0;
            frame_start_q <= 1'b0;
            pend_number_q <= '0;
            pend_dots_q   <= '0;
            pend_en_q     <= '0;
            pend_valid_q  <= 1'b0;
            sh_number_q   <= '0;
            sh_dots_q     <= '0;
            sh_en_q       <= '0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            abcdefgh_q    <= abcdefgh_d;
            digit_q       <= digit_d;
            frame_start_q <= frame_start_d;
            pend_number_q <= pend_number_d;
            pend_dots_q   <= pend_dots_d;
            pend_en_q     <= pend_en_d;
            pend_valid_q  <= pend_valid_d;
            sh_number_q   <= sh_number_d;
            sh_dots_q     <= sh_dots_d;
            sh_en_q       <= sh_en_d;
        end
    end

    assign abcdefgh    = abcdefgh_q;
    assign digit       = digit_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits and a 4-cycle digit slot.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] number;
    logic [3:0]  dots;
    logic [3:0]  en_mask;
    logic        blank_lz;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;
    logic        frame_start;

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    seg7_scan_driver #(
        .clk_mhz    (1),
        .w_digit    (4),
        .refresh_hz (62500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .number      (number),
        .dots        (dots),
        .en_mask     (en_mask),
        .blank_lz    (blank_lz),
        .abcdefgh    (abcdefgh),
        .digit       (digit),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_blank(input bit fs);
        chk("blank_seg", 32'(abcdefgh), 32'h0);
        chk("blank_dig", 32'(digit), 32'h0);
        chk("frame_start", 32'(frame_start), 32'(fs));
    endtask

    task automatic check_lit(input int i, input logic [7:0] e);
        logic [3:0] exp_dig;
        exp_dig = 4'b0001 << i;
        chk("digit", 32'(digit), 32'(exp_dig));
        chk("seg", 32'(abcdefgh), 32'(e));
        chk("frame_start_lit", 32'(frame_start), 32'h0);
    endtask

    task automatic check_slot(input int i, input logic [7:0] e);
        check_blank(i == 0);
        repeat (3) begin
            @(negedge clk);
            check_lit(i, e);
        end
    endtask

    // exp packs {digit3, digit2, digit1, digit0}; starts on the frame_start cycle.
    task automatic check_frame(input logic [31:0] exp);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) @(negedge clk);
            check_slot(s, exp[8*s +: 8]);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_fs", 32'(frame_start), 32'h1);
    endtask

    task automatic pulse_load(input logic [15:0] num, input logic [3:0] dts, input logic [3:0] en);
        number  = num;
        dots    = dts;
        en_mask = en;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; number = '0; dots = '0; en_mask = '0; blank_lz = 1'b0;

        phase = "reset";
        repeat (3) @(negedge clk);
        check_blank(1'b0);

        phase = "reset_scan";
        rst = 1'b0;
        pulse_load(16'h12AF, 4'h0, 4'hF);
        check_lit(0, 8'h00);
        wait_fs();
        check_frame({8'h60, 8'hDA, 8'hEE, 8'h8E});
        wait_fs();
        check_frame({8'h60, 8'hDA, 8'hEE, 8'h8E});

        phase = "tear_free";
        pulse_load(16'h1234, 4'h0, 4'hF);
        check_frame({8'h60, 8'hDA, 8'hF2, 8'h66});
        wait_fs();
        check_slot(0, 8'h66);
        @(negedge clk);
        check_blank(1'b0);
        pulse_load(16'h5678, 4'h0, 4'hF);
        check_lit(1, 8'hF2);
        repeat (2) begin
            @(negedge clk);
            check_lit(1, 8'hF2);
        end
        @(negedge clk);
        check_slot(2, 8'hDA);
        @(negedge clk);
        check_slot(3, 8'h60);
        wait_fs();
        check_frame({8'hB6, 8'hBE, 8'hE0, 8'hFE});

        phase = "wrap_load";
        @(negedge clk);
        pulse_load(16'h000A, 4'h0, 4'hF);
        repeat (14) @(negedge clk);
        pulse_load(16'h0009, 4'h0, 4'hF);
        check_frame({8'hFC, 8'hFC, 8'hFC, 8'hF6});
        chk("pend_valid", 32'(dut.pend_valid_q), 32'h0);
        wait_fs();
        check_frame({8'hFC, 8'hFC, 8'hFC, 8'hF6});

        phase = "lead_zero";
        blank_lz = 1'b1;
        pulse_load(16'h0050, 4'h0, 4'hF);
        check_frame({8'h00, 8'h00, 8'hB6, 8'hFC});
        blank_lz = 1'b0;
        wait_fs();
        check_frame({8'hFC, 8'hFC, 8'hB6, 8'hFC});

        phase = "dots_mask";
        pulse_load(16'h8888, 4'b0101, 4'b1011);
        check_frame({8'hFE, 8'h00, 8'hFE, 8'hFF});

        phase = "reset_mid";
        @(negedge clk);
        pulse_load(16'h1234, 4'h0, 4'hF);
        repeat (7) @(negedge clk);
        rst     = 1'b1;
        number  = 16'h5678;
        en_mask = 4'hF;
        load    = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        check_blank(1'b0);
        chk("shadow_num", 32'(dut.sh_number_q), 32'h0);
        chk("shadow_en", 32'(dut.sh_en_q), 32'h0);
        chk("pend_valid_rst", 32'(dut.pend_valid_q), 32'h0);
        @(negedge clk);
        check_lit(0, 8'h00);
        wait_fs();
        check_frame(32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
